// File: rtl/vli_pkg.sv
// rtl/vli_pkg.sv - shared helpers for the VLI size/amplitude encoder
package vli_pkg;

   function automatic int vli_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // All-ones in the low n bits; callers cast down to their own width.
   function automatic logic [31:0] low_mask(input int unsigned n);
      return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
   endfunction

endpackage

// File: rtl/vli_size_encoder_size_prio_enc.sv
// rtl/vli_size_encoder_size_prio_enc.sv - bit-length priority encoder for a W-bit magnitude
module size_prio_enc #(
   parameter int W  = 11,
   parameter int SW = 4
) (
   input  logic [W-1:0]  mag,
   output logic [SW-1:0] size
);

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      size = '0;
      for (int i = 0; i < W; i++) begin
         if (mag[i]) size = SW'(i + 1);
      end
   end

endmodule

// File: rtl/vli_size_encoder.sv
// rtl/vli_size_encoder.sv - two-stage size/amplitude encoder with per-channel DC prediction
module vli_size_encoder
   import vli_pkg::*;
#(
   parameter int DATA_W = 11,
   parameter int NUM_CH = 3,
   parameter int CH_W   = 2,
   parameter int SIZE_W = vli_clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   in_ch,
   input  logic              in_dc,
   input  logic              in_signed,
   input  logic              pred_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SIZE_W-1:0] out_size,
   output logic [DATA_W-1:0] out_amp,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_dc
);

   logic [DATA_W-1:0] pred [NUM_CH];

   logic              s1_valid;
   logic [DATA_W-1:0] s1_mag;
   logic              s1_neg;
   logic [CH_W-1:0]   s1_ch;
   logic              s1_dc;

   logic              s1_en, s2_en, accept, dc_eff, ch_ok;
   logic [DATA_W-1:0] pred_sel;
   logic [DATA_W:0]   v;
   logic [DATA_W-1:0] v_abs;
   logic [SIZE_W-1:0] enc_size;
   logic [DATA_W-1:0] amp_next;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = !rst && s1_en;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle means the DC sample sees a zero predictor.
   always_comb begin
      dc_eff   = in_dc && in_signed;
      ch_ok    = (32'(in_ch) < 32'(NUM_CH));
      pred_sel = '0;
      if (dc_eff && ch_ok && !pred_clr) pred_sel = pred[in_ch];
      if (!in_signed) v = {1'b0, in_data};
      else            v = {in_data[DATA_W-1], in_data} - {pred_sel[DATA_W-1], pred_sel};
      v_abs = v[DATA_W] ? DATA_W'(-v) : v[DATA_W-1:0];
   end

   size_prio_enc #(.W(DATA_W), .SW(SIZE_W)) u_size_enc (
      .mag  (s1_mag),
      .size (enc_size)
   );

   // For negatives, (v-1) in the low size bits equals the inverted magnitude.
   always_comb begin
      amp_next = s1_neg ? (~s1_mag & DATA_W'(low_mask(32'(enc_size)))) : s1_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_mag    <= '0;
         s1_neg    <= 1'b0;
         s1_ch     <= '0;
         s1_dc     <= 1'b0;
         out_valid <= 1'b0;
         out_size  <= '0;
         out_amp   <= '0;
         out_ch    <= '0;
         out_dc    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) pred[i] <= '0;
      end else begin
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_size <= enc_size;
               out_amp  <= amp_next;
               out_ch   <= s1_ch;
               out_dc   <= s1_dc;
            end
         end
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_mag <= v_abs;
               s1_neg <= v[DATA_W];
               s1_ch  <= in_ch;
               s1_dc  <= dc_eff;
            end
         end
         if (pred_clr) begin
            for (int i = 0; i < NUM_CH; i++) pred[i] <= '0;
         end
         if (accept && dc_eff && ch_ok) pred[in_ch] <= in_data;
      end
   end

endmodule

// File: tb/tb_vli_size_encoder.sv
// tb/tb_vli_size_encoder.sv - directed self-checking bench for vli_size_encoder
module tb_vli_size_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] in_data = '0;
   logic [1:0]  in_ch = '0;
   logic        in_dc = 1'b0;
   logic        in_signed = 1'b0;
   logic        pred_clr = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_size;
   logic [10:0] out_amp;
   logic [1:0]  out_ch;
   logic        out_dc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vli_size_encoder #(.DATA_W(11), .NUM_CH(3), .CH_W(2), .SIZE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ch     (in_ch),
      .in_dc     (in_dc),
      .in_signed (in_signed),
      .pred_clr  (pred_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_size  (out_size),
      .out_amp   (out_amp),
      .out_ch    (out_ch),
      .out_dc    (out_dc)
   );

   // Drives one sample into an empty pipeline and captures what comes out.
   task automatic xfer(input logic [10:0] d, input logic [1:0] ch, input logic dc,
                       input logic sg, input logic clr,
                       output logic rdy, output logic early, output logic vld,
                       output logic [3:0] sz, output logic [10:0] am,
                       output logic [1:0] och, output logic odc);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_ch = ch; in_dc = dc;
      in_signed = sg; pred_clr = clr; out_ready = 1'b1;
      #1 rdy = in_ready;
      @(negedge clk);
      in_valid = 1'b0; in_dc = 1'b0; pred_clr = 1'b0;
      early = out_valid;
      @(negedge clk);
      vld = out_valid; sz = out_size; am = out_amp; och = out_ch; odc = out_dc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_size, out_amp, out_ch, out_dc} !== 20'd0) begin
         n_err++;
         $display("FAIL reset_state got rdy=%b v=%b size=%0d amp=%0d ch=%0d dc=%b, want all 0",
                  in_ready, out_valid, out_size, out_amp, out_ch, out_dc);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_unsigned();
      logic [10:0] d  [6] = '{11'd0, 11'd1, 11'd3, 11'd4, 11'd1023, 11'd2047};
      logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd10, 4'd11};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      for (int k = 0; k < 6; k++) begin
         xfer(d[k], 2'd0, 1'b0, 1'b0, 1'b0, rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({rdy, early, vld, sz, am, odc} !== {1'b1, 1'b0, 1'b1, es[k], d[k], 1'b0}) begin
            n_err++;
            $display("FAIL unsigned[%0d] got rdy=%b early=%b v=%b size=%0d amp=%0d dc=%b want size=%0d amp=%0d latency 2",
                     k, rdy, early, vld, sz, am, odc, es[k], d[k]);
         end
      end
   endtask

   task automatic test_signed_ac();
      logic [10:0] d  [5] = '{11'h7FF, 11'h7FB, 11'd5, 11'h400, 11'd1023};
      logic [3:0]  es [5] = '{4'd1, 4'd3, 4'd3, 4'd11, 4'd10};
      logic [10:0] ea [5] = '{11'd0, 11'd2, 11'd5, 11'd1023, 11'd1023};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      for (int k = 0; k < 5; k++) begin
         xfer(d[k], 2'd1, 1'b0, 1'b1, 1'b0, rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({vld, sz, am, och, odc} !== {1'b1, es[k], ea[k], 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL signed_ac[%0d] got v=%b size=%0d amp=%0d ch=%0d dc=%b want size=%0d amp=%0d ch=1 dc=0",
                     k, vld, sz, am, och, odc, es[k], ea[k]);
         end
      end
   endtask

   task automatic test_dc_ch0();
      logic [10:0] d  [5] = '{11'd100, 11'd90, 11'd90, 11'd200, 11'd90};
      logic [1:0]  c  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
      logic [3:0]  es [5] = '{4'd7, 4'd4, 4'd0, 4'd8, 4'd0};
      logic [10:0] ea [5] = '{11'd100, 11'd5, 11'd0, 11'd200, 11'd0};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      for (int k = 0; k < 5; k++) begin
         xfer(d[k], c[k], 1'b1, 1'b1, 1'b0, rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({vld, sz, am, och, odc} !== {1'b1, es[k], ea[k], c[k], 1'b1}) begin
            n_err++;
            $display("FAIL dc_ch0[%0d] got v=%b size=%0d amp=%0d ch=%0d dc=%b want size=%0d amp=%0d ch=%0d dc=1",
                     k, vld, sz, am, och, odc, es[k], ea[k], c[k]);
         end
      end
   endtask

   task automatic test_dc_extremes();
      logic [10:0] d  [3] = '{11'd1023, 11'h400, 11'd1023};
      logic [3:0]  es [3] = '{4'd10, 4'd11, 4'd11};
      logic [10:0] ea [3] = '{11'd1023, 11'd0, 11'd2047};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      for (int k = 0; k < 3; k++) begin
         xfer(d[k], 2'd2, 1'b1, 1'b1, 1'b0, rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({vld, sz, am, och, odc} !== {1'b1, es[k], ea[k], 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL dc_extreme[%0d] got v=%b size=%0d amp=%0d ch=%0d dc=%b want size=%0d amp=%0d",
                     k, vld, sz, am, och, odc, es[k], ea[k]);
         end
      end
   endtask

   // Unsigned DC is plain, out-of-range channel uses pred 0, ch0 predictor (90) untouched.
   task automatic test_dc_corner();
      logic [10:0] d  [3] = '{11'd5, 11'd7, 11'd90};
      logic [1:0]  c  [3] = '{2'd0, 2'd3, 2'd0};
      logic        sg [3] = '{1'b0, 1'b1, 1'b1};
      logic [3:0]  es [3] = '{4'd3, 4'd3, 4'd0};
      logic [10:0] ea [3] = '{11'd5, 11'd7, 11'd0};
      logic        ed [3] = '{1'b0, 1'b1, 1'b1};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      for (int k = 0; k < 3; k++) begin
         xfer(d[k], c[k], 1'b1, sg[k], 1'b0, rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({vld, sz, am, och, odc} !== {1'b1, es[k], ea[k], c[k], ed[k]}) begin
            n_err++;
            $display("FAIL dc_corner[%0d] got v=%b size=%0d amp=%0d ch=%0d dc=%b want size=%0d amp=%0d ch=%0d dc=%b",
                     k, vld, sz, am, och, odc, es[k], ea[k], c[k], ed[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] bp_vals [8] = '{11'd1, 11'd2, 11'd4, 11'd8, 11'd16, 11'd32, 11'd64, 11'd128};
      logic [3:0]  bp_sz   [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      int i = 0;
      int j = 0;
      int acc_stall = 0;
      for (int cyc = 0; cyc < 40 && j < 8; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         in_signed = 1'b0; in_dc = 1'b0; in_ch = 2'd0; pred_clr = 1'b0;
         in_valid = (i < 8);
         if (i < 8) in_data = bp_vals[i];
         #1;
         if (cyc == 2 || cyc == 4) begin
            n_vec++;
            if ({out_valid, out_size, out_amp} !== {1'b1, 4'd1, 11'd1}) begin
               n_err++;
               $display("FAIL bp_hold@%0d got v=%b size=%0d amp=%0d want v=1 size=1 amp=1",
                        cyc, out_valid, out_size, out_amp);
            end
         end
         if (cyc == 4) begin
            n_vec++;
            if (in_ready !== 1'b0 || acc_stall != 2) begin
               n_err++;
               $display("FAIL bp_full got in_ready=%b accepts=%0d want in_ready=0 accepts=2",
                        in_ready, acc_stall);
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if ({out_size, out_amp} !== {bp_sz[j], bp_vals[j]}) begin
               n_err++;
               $display("FAIL bp_order[%0d] got size=%0d amp=%0d want size=%0d amp=%0d",
                        j, out_size, out_amp, bp_sz[j], bp_vals[j]);
            end
            j++;
         end
         if (in_valid && in_ready) begin
            i++;
            if (cyc < 5) acc_stall++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_vec++;
      if (j != 8) begin
         n_err++;
         $display("FAIL bp_drain got %0d results want 8 within cycle budget", j);
      end
   endtask

   task automatic test_pred_clr();
      logic [10:0] d   [3] = '{11'd30, 11'd50, 11'd50};
      logic        clr [3] = '{1'b0, 1'b1, 1'b0};
      logic [3:0]  es  [3] = '{4'd5, 4'd6, 4'd0};
      logic [10:0] ea  [3] = '{11'd30, 11'd50, 11'd0};
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      xfer(11'd0, 2'd0, 1'b1, 1'b1, 1'b1, rdy, early, vld, sz, am, och, odc);
      for (int k = 0; k < 3; k++) begin
         xfer(d[k], 2'd0, 1'b1, 1'b1, clr[k], rdy, early, vld, sz, am, och, odc);
         n_vec++;
         if ({vld, sz, am, odc} !== {1'b1, es[k], ea[k], 1'b1}) begin
            n_err++;
            $display("FAIL pred_clr[%0d] got v=%b size=%0d amp=%0d dc=%b want size=%0d amp=%0d",
                     k, vld, sz, am, odc, es[k], ea[k]);
         end
      end
   endtask

   task automatic test_rst_mid();
      logic rdy, early, vld, odc;
      logic [3:0] sz; logic [10:0] am; logic [1:0] och;
      xfer(11'd100, 2'd1, 1'b1, 1'b1, 1'b1, rdy, early, vld, sz, am, och, odc);
      n_vec++;
      if ({vld, sz, am, och, odc} !== {1'b1, 4'd7, 11'd100, 2'd1, 1'b1}) begin
         n_err++;
         $display("FAIL rst_pre got v=%b size=%0d amp=%0d ch=%0d dc=%b want 7/100/1/1",
                  vld, sz, am, och, odc);
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = 11'd5; in_signed = 1'b0; in_dc = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_data = 11'd6;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({in_ready, out_valid} !== 2'b01) begin
         n_err++;
         $display("FAIL rst_mid_ready got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_size, out_amp} !== 16'd0) begin
         n_err++;
         $display("FAIL rst_mid_flush got v=%b size=%0d amp=%0d want 0", out_valid, out_size, out_amp);
      end
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_discard got out_valid=%b want 0", out_valid);
      end
      xfer(11'd100, 2'd1, 1'b1, 1'b1, 1'b0, rdy, early, vld, sz, am, och, odc);
      n_vec++;
      if ({vld, sz, am} !== {1'b1, 4'd7, 11'd100}) begin
         n_err++;
         $display("FAIL rst_pred_cleared got v=%b size=%0d amp=%0d want size=7 amp=100", vld, sz, am);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed_ac();
      test_dc_ch0();
      test_dc_extremes();
      test_dc_corner();
      test_backpressure();
      test_pred_clr();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
